alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter EXEC_CYCLES, default 1, range 1-15: cycles operands are held on the ALU before result capture.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 reqN_valid  in  1  (N=0,1) requester N presents an operation.
REQ-005 reqN_ready  out  1  (N=0,1) arbiter accepts requester N this cycle.
REQ-006 reqN_a, reqN_b  in  32 each  (N=0,1) operands A and B.
REQ-007 reqN_op  in  4  (N=0,1) ALU operation code; reqN_shamt  in  5  shift amount.
REQ-008 rspN_valid  out  1  (N=0,1) result pending for requester N; rspN_ready  in  1  requester N consumes it.
REQ-009 rsp_res  out  32, rsp_zero  out  1, rsp_overflow  out  1: shared registered result bus, valid only with rspN_valid.
REQ-010 alu_a, alu_b  out  32, alu_op  out  4, alu_shamt  out  5: drive the shared ALU.
REQ-011 alu_res  in  32, alu_zero  in  1, alu_overflow  in  1: shared ALU outputs.
REQ-012 busy  out  1 high when state is not IDLE; grant_id  out  1 index of the current/last granted requester.

Function
REQ-013 The state machine SHALL have states IDLE, EXEC, RESP.
REQ-014 IDLE: reqN_ready=1 only for the arbitration winner with reqN_valid=1; at most one ready per cycle; handshake = valid&ready.
REQ-015 On handshake, operands/op/shamt SHALL be latched, grant_id set to the winner, exec counter loaded with EXEC_CYCLES-1, next state EXEC.
REQ-016 EXEC: alu_* SHALL be driven from latched registers, held stable; counter decrements each cycle; when counter=0, alu_res/zero/overflow SHALL be registered into rsp_* and state goes to RESP.
REQ-017 Latency: handshake in cycle T -> rspN_valid high from cycle T+EXEC_CYCLES+1.
REQ-018 RESP: rspN_valid high for N=grant_id only, held with rsp_* stable until rspN_ready=1; on that edge go to IDLE.
REQ-019 A new request SHALL NOT be accepted in the cycle the response is consumed; earliest next handshake is the following cycle (no bypass).
REQ-020 Outside EXEC alu_a, alu_b, alu_shamt SHALL be 0 and alu_op SHALL be 4'b0000.
REQ-021 Round-robin: if both valid in IDLE, winner is the requester not equal to grant_id; if one valid, it wins regardless.
REQ-022 Requester deasserting reqN_valid before handshake SHALL be legal and cause no state change.
REQ-023 rspN_ready asserted while rspN_valid=0 SHALL be ignored.
REQ-024 Opcodes SHALL be passed through unmodified; no opcode decoding or checking in this block.

Reset
REQ-025 With rst=1 at a clock edge: state=IDLE, grant_id=1 (requester 0 wins the first tie), counter=0, rsp_res=0, rsp_zero=0, rsp_overflow=0, latched operands=0.
REQ-026 During rst=1 all reqN_ready and rspN_valid SHALL be 0; busy=0.
REQ-027 Reset in EXEC or RESP SHALL abort the operation; its response is discarded and never presented.

Configuration
REQ-028 Macro ALU_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win simultaneous requests and grant_id does not influence arbitration; when undefined, round-robin per REQ-021 applies.

Verification
REQ-029 Single op: EXEC_CYCLES=1, req0 A=5 B=3 op=0010 -> rsp0_valid at T+2, rsp_res=8, rsp_zero=0; rsp1_valid stays 0.
REQ-030 Tie: both valid after reset, req0 op=0110 A=B=7, req1 op=0001 A=1 B=2 -> req0 first (res=0, zero=1), then req1 (res=3); repeated tie alternates (without ALU_ARB_FIXED_PRIO_EN); with macro, req0 wins every tie.
REQ-031 Backpressure: hold rsp0_ready=0 10 cycles -> rsp0_valid and rsp_res stable, req0_ready/req1_ready=0, alu_op=0000 throughout.
REQ-032 EXEC_CYCLES=4: req1 B=32'h80000000 shamt=4 op=0101 -> alu_* stable 4 cycles, rsp_res=32'h08000000 at T+5.
REQ-033 Reset mid-EXEC -> next cycle state IDLE, no rspN_valid, busy=0, next request completes normally with grant to req0 on tie.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared external ALU: IDLE -> EXEC -> RESP.
// Optional macro ALU_ARB_FIXED_PRIO_EN gives requester 0 fixed priority instead of round-robin.
module alu_arbiter #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic [4:0]  req0_shamt,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  input  logic [4:0]  req1_shamt,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_res,
  output logic        rsp_zero,
  output logic        rsp_overflow,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_res,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        busy,
  output logic        grant_id
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [31:0] op_a, op_b;
  logic [3:0]  op_code;
  logic [4:0]  op_shamt;
  logic        winner;
  logic        handshake;
  logic        rsp_take;

  always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    winner = !req0_valid;
`else
    // On a tie the requester that was not granted last time wins.
    winner = req0_valid ? (req1_valid ? ~grant_id : 1'b0) : 1'b1;
`endif
  end

  // Ready, response valid and busy are all forced low while reset is held.
  assign req0_ready = (state == IDLE) && !rst && req0_valid && !winner;
  assign req1_ready = (state == IDLE) && !rst && req1_valid &&  winner;
  assign handshake  = req0_ready || req1_ready;

  assign rsp0_valid = (state == RESP) && !rst && !grant_id;
  assign rsp1_valid = (state == RESP) && !rst &&  grant_id;
  assign rsp_take   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  assign busy = (state != IDLE) && !rst;

  assign alu_a     = (state == EXEC) ? op_a     : 32'd0;
  assign alu_b     = (state == EXEC) ? op_b     : 32'd0;
  assign alu_op    = (state == EXEC) ? op_code  : 4'b0000;
  assign alu_shamt = (state == EXEC) ? op_shamt : 5'd0;

  // NOTE: every output of a combinational block gets a default first, otherwise unlisted paths infer latches.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (handshake) state_nxt = EXEC;
      EXEC: if (cnt == 4'd0) state_nxt = RESP;
      RESP: if (rsp_take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant_id     <= 1'b1;
      cnt          <= 4'd0;
      op_a         <= 32'd0;
      op_b         <= 32'd0;
      op_code      <= 4'b0000;
      op_shamt     <= 5'd0;
      rsp_res      <= 32'd0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (handshake) begin
        grant_id <= winner;
        cnt      <= 4'(EXEC_CYCLES - 1);
        op_a     <= winner ? req1_a     : req0_a;
        op_b     <= winner ? req1_b     : req0_b;
        op_code  <= winner ? req1_op    : req0_op;
        op_shamt <= winner ? req1_shamt : req0_shamt;
      end else if (state == EXEC && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state == EXEC && cnt == 4'd0) begin
        rsp_res      <= alu_res;
        rsp_zero     <= alu_zero;
        rsp_overflow <= alu_overflow;
      end
    end
  end

endmodule
